// File: rtl/sram_like_arbiter.sv
// 2:1 arbiter sharing one SRAM-like port between inst fetch and data access.
// Response ownership is tracked by an in-order tag FIFO; inst starvation is bounded.
module sram_like_arbiter #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int STARVE_LIMIT    = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   localparam logic [CW-1:0] CNT_FULL   = CW'(MAX_OUTSTANDING);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [PW-1:0] PTR_LAST   = PW'(MAX_OUTSTANDING - 1);

   logic [MAX_OUTSTANDING-1:0] tag_q;
   logic [PW-1:0]              wr_ptr;
   logic [PW-1:0]              rd_ptr;
   logic [CW-1:0]              count;
   logic [SW-1:0]              starve_cnt;
   logic                       lock_valid;
   logic                       lock_sel;

   logic full;
   logic sel_data;
   logic accept;
   logic push;
   logic pop;
   logic head_tag;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign full = (count == CNT_FULL);

   // A pending lock pins the winner until the downstream accepts it.
   always_comb begin
      sel_data = 1'b0;
      if (lock_valid)
         sel_data = lock_sel;
      else if (inst_req && !data_req)
         sel_data = 1'b0;
      else if (data_req && !inst_req)
         sel_data = 1'b1;
      else if (inst_req && data_req)
         sel_data = (starve_cnt != STARVE_MAX);
   end

   assign mem_req   = (inst_req | data_req) & ~full & ~reset;
   assign mem_wr    = sel_data & data_wr;
   assign mem_size  = sel_data ? data_size  : 2'd2;
   assign mem_wstrb = sel_data ? data_wstrb : 4'b0000;
   assign mem_addr  = sel_data ? data_addr  : inst_addr;
   assign mem_wdata = sel_data ? data_wdata : 32'd0;

   assign accept = mem_req & mem_addr_ok;
   assign push   = accept;

   assign inst_addr_ok = accept & ~sel_data;
   assign data_addr_ok = accept & sel_data;

   // Responses with nothing outstanding are stale and dropped.
   assign head_tag = tag_q[rd_ptr];
   assign pop      = mem_data_ok & (count != '0) & ~reset;

   assign inst_data_ok = pop & ~head_tag;
   assign data_data_ok = pop & head_tag;

   assign inst_rdata = mem_rdata;
   assign data_rdata = mem_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         tag_q  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            tag_q[wr_ptr] <= sel_data;
            wr_ptr        <= ptr_inc(wr_ptr);
         end
         if (pop)
            rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         starve_cnt <= '0;
      else if (!inst_req)
         starve_cnt <= '0;
      else if (accept && !sel_data)
         starve_cnt <= '0;
      else if (accept && starve_cnt != STARVE_MAX)
         starve_cnt <= starve_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lock_valid <= 1'b0;
         lock_sel   <= 1'b0;
      end else if (mem_req && !mem_addr_ok) begin
         lock_valid <= 1'b1;
         lock_sel   <= sel_data;
      end else if (accept) begin
         lock_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed vector table, corner sequences,
// then random traffic against a queue-based reference model.
module tb_sram_like_arbiter;

   localparam int MAXO = 2;
   localparam int LIM  = 3;

   localparam logic [31:0] A_I  = 32'h1c000000;
   localparam logic [31:0] A_I2 = 32'h1c000010;
   localparam logic [31:0] RD   = 32'h02800000;
   localparam logic [31:0] D1   = 32'h80001000;
   localparam logic [31:0] D2   = 32'h80002004;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;

   typedef struct packed {
      logic        rst;
      logic        ireq;
      logic [31:0] iaddr;
      logic        dreq;
      logic        dwr;
      logic [1:0]  dsize;
      logic [3:0]  dstrb;
      logic [31:0] daddr;
      logic [31:0] dwdata;
      logic        aok;
      logic        dok;
      logic [31:0] rdata;
   } in_t;

   typedef struct packed {
      logic        mreq;
      logic        iaok;
      logic        daok;
      logic        idok;
      logic        ddok;
      logic        mwr;
      logic [1:0]  msize;
      logic [3:0]  mstrb;
      logic [31:0] maddr;
      logic [31:0] mwdata;
   } out_t;

   typedef struct {
      string name;
      in_t   i;
      out_t  o;
   } vec_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t tbl[$];

   int m_q[$];
   int m_starve = 0;
   int m_lock   = -1;

   sram_like_arbiter #(
      .MAX_OUTSTANDING(MAXO),
      .STARVE_LIMIT(LIM)
   ) dut (
      .clk(clk),
      .reset(reset),
      .inst_req(inst_req),
      .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok),
      .inst_rdata(inst_rdata),
      .data_req(data_req),
      .data_wr(data_wr),
      .data_size(data_size),
      .data_wstrb(data_wstrb),
      .data_addr(data_addr),
      .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok),
      .data_rdata(data_rdata),
      .mem_req(mem_req),
      .mem_wr(mem_wr),
      .mem_size(mem_size),
      .mem_wstrb(mem_wstrb),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok),
      .mem_data_ok(mem_data_ok),
      .mem_rdata(mem_rdata)
   );

   function automatic in_t ii(logic ir, logic dr, logic aok, logic dok);
      in_t t;
      t       = '0;
      t.ireq  = ir;
      t.iaddr = A_I;
      t.dreq  = dr;
      t.dsize = 2'd2;
      t.daddr = D1;
      t.aok   = aok;
      t.dok   = dok;
      return t;
   endfunction

   function automatic out_t o_none(logic idok, logic ddok);
      out_t t;
      t      = '0;
      t.idok = idok;
      t.ddok = ddok;
      return t;
   endfunction

   function automatic out_t o_inst(logic ok, logic [31:0] a, logic idok, logic ddok);
      out_t t;
      t       = '0;
      t.mreq  = 1'b1;
      t.iaok  = ok;
      t.msize = 2'd2;
      t.maddr = a;
      t.idok  = idok;
      t.ddok  = ddok;
      return t;
   endfunction

   function automatic out_t o_data(logic ok, in_t i, logic idok, logic ddok);
      out_t t;
      t        = '0;
      t.mreq   = 1'b1;
      t.daok   = ok;
      t.mwr    = i.dwr;
      t.msize  = i.dsize;
      t.mstrb  = i.dstrb;
      t.maddr  = i.daddr;
      t.mwdata = i.dwdata;
      t.idok   = idok;
      t.ddok   = ddok;
      return t;
   endfunction

   task automatic add(input string name, input in_t i, input out_t o);
      vec_t v;
      v.name = name;
      v.i    = i;
      v.o    = o;
      tbl.push_back(v);
   endtask

   task automatic drive(input in_t i);
      reset       = i.rst;
      inst_req    = i.ireq;
      inst_addr   = i.iaddr;
      data_req    = i.dreq;
      data_wr     = i.dwr;
      data_size   = i.dsize;
      data_wstrb  = i.dstrb;
      data_addr   = i.daddr;
      data_wdata  = i.dwdata;
      mem_addr_ok = i.aok;
      mem_data_ok = i.dok;
      mem_rdata   = i.rdata;
   endtask

   task automatic check(input string name, input in_t i, input out_t e);
      out_t a;
      bit   ok;
      a.mreq   = mem_req;
      a.iaok   = inst_addr_ok;
      a.daok   = data_addr_ok;
      a.idok   = inst_data_ok;
      a.ddok   = data_data_ok;
      a.mwr    = mem_wr;
      a.msize  = mem_size;
      a.mstrb  = mem_wstrb;
      a.maddr  = mem_addr;
      a.mwdata = mem_wdata;
      if (!e.mreq) begin
         a.mwr    = 1'b0;
         a.msize  = 2'd0;
         a.mstrb  = 4'd0;
         a.maddr  = 32'd0;
         a.mwdata = 32'd0;
      end
      ok = (a == e) && (inst_rdata == i.rdata) && (data_rdata == i.rdata);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got out=%h rdata=%h/%h, want out=%h rdata=%h",
                  name, a, inst_rdata, data_rdata, e, i.rdata);
      end
   endtask

   task automatic apply(input string name, input in_t i, input out_t e);
      @(negedge clk);
      if (i.rdata == 32'd0)
         i.rdata = $urandom();
      drive(i);
      #1;
      check(name, i, e);
   endtask

   // Reference: winner from spec rules, tags kept in a plain queue.
   task automatic model_step(input in_t i, output out_t o);
      bit full;
      bit acc;
      bit pop;
      int win;
      full = (m_q.size() == MAXO);
      if (m_lock >= 0)
         win = m_lock;
      else if (i.ireq && !i.dreq)
         win = 0;
      else if (!i.ireq && i.dreq)
         win = 1;
      else if (i.ireq && i.dreq)
         win = (m_starve == LIM) ? 0 : 1;
      else
         win = 0;
      o      = '0;
      o.mreq = (i.ireq || i.dreq) && !full && !i.rst;
      if (o.mreq) begin
         if (win == 1) begin
            o.mwr    = i.dwr;
            o.msize  = i.dsize;
            o.mstrb  = i.dstrb;
            o.maddr  = i.daddr;
            o.mwdata = i.dwdata;
         end else begin
            o.msize = 2'd2;
            o.maddr = i.iaddr;
         end
      end
      acc    = o.mreq && i.aok;
      o.iaok = acc && (win == 0);
      o.daok = acc && (win == 1);
      pop    = i.dok && (m_q.size() > 0) && !i.rst;
      o.idok = pop && (m_q[0] == 0);
      o.ddok = pop && (m_q[0] == 1);
      if (i.rst) begin
         m_q.delete();
         m_starve = 0;
         m_lock   = -1;
      end else begin
         if (pop)
            void'(m_q.pop_front());
         if (acc)
            m_q.push_back(win);
         if (o.mreq && !i.aok)
            m_lock = win;
         else if (acc)
            m_lock = -1;
         if (!i.ireq)
            m_starve = 0;
         else if (acc && win == 0)
            m_starve = 0;
         else if (acc && m_starve < LIM)
            m_starve++;
      end
   endtask

   initial begin
      in_t  t;
      in_t  st;
      in_t  cur;
      in_t  nxt;
      out_t e;
      bit   i_acc;
      bit   d_acc;

      drive(ii(0, 0, 0, 0));
      reset = 1'b1;

      t = ii(1, 1, 1, 1);
      t.rst = 1'b1;
      add("rst0", t, o_none(0, 0));
      add("rst1", t, o_none(0, 0));
      add("inst_req", ii(1, 0, 1, 0), o_inst(1, A_I, 0, 0));
      t = ii(0, 0, 0, 1);
      t.rdata = RD;
      add("inst_rsp", t, o_none(1, 0));
      st = ii(0, 1, 1, 0);
      st.dwr    = 1'b1;
      st.dsize  = 2'd0;
      st.dstrb  = 4'b0100;
      st.daddr  = 32'h1c0000a2;
      st.dwdata = 32'h00ab0000;
      add("store", st, o_data(1, st, 0, 0));
      add("store_rsp", ii(0, 0, 0, 1), o_none(0, 1));
      add("stale_rsp", ii(0, 0, 0, 1), o_none(0, 0));
      t = ii(1, 1, 1, 0);
      add("cont_d1", t, o_data(1, t, 0, 0));
      t = ii(1, 1, 1, 1);
      add("cont_d2", t, o_data(1, t, 0, 1));
      add("cont_d3", t, o_data(1, t, 0, 1));
      add("cont_i1", t, o_inst(1, A_I, 0, 1));
      add("cont_d4", t, o_data(1, t, 1, 0));
      add("cont_d5", t, o_data(1, t, 0, 1));
      add("cont_d6", t, o_data(1, t, 0, 1));
      add("cont_i2", t, o_inst(1, A_I, 0, 1));
      add("cont_drain", ii(0, 0, 0, 1), o_none(1, 0));

      foreach (tbl[k])
         apply(tbl[k].name, tbl[k].i, tbl[k].o);

      // Full: two outstanding block a third; a pop does not unblock that cycle.
      apply("full_i", ii(1, 0, 1, 0), o_inst(1, A_I, 0, 0));
      t = ii(0, 1, 1, 0);
      apply("full_d", t, o_data(1, t, 0, 0));
      apply("full_blk1", t, o_none(0, 0));
      apply("full_blk2", t, o_none(0, 0));
      t = ii(0, 1, 1, 1);
      apply("full_pop_i", t, o_none(1, 0));
      t = ii(0, 1, 1, 0);
      apply("full_reopen", t, o_data(1, t, 0, 0));
      apply("full_pop_d1", ii(0, 0, 0, 1), o_none(0, 1));
      apply("full_pop_d2", ii(0, 0, 0, 1), o_none(0, 1));
      apply("full_stale", ii(0, 0, 0, 1), o_none(0, 0));

      // Lock on inst holds against a later data request.
      t = ii(1, 0, 0, 0);
      t.iaddr = A_I2;
      apply("lk_i_wait", t, o_inst(0, A_I2, 0, 0));
      t = ii(1, 1, 0, 0);
      t.iaddr = A_I2;
      t.daddr = D2;
      apply("lk_i_hold", t, o_inst(0, A_I2, 0, 0));
      t.aok = 1'b1;
      apply("lk_i_acc", t, o_inst(1, A_I2, 0, 0));
      t = ii(0, 1, 0, 1);
      t.daddr = D2;
      apply("lk_d_wait", t, o_data(0, t, 1, 0));
      t = ii(1, 1, 0, 0);
      t.daddr = D2;
      apply("lk_d_hold", t, o_data(0, t, 0, 0));
      t.aok = 1'b1;
      apply("lk_d_acc", t, o_data(1, t, 0, 0));
      apply("lk_i_next", ii(1, 0, 1, 1), o_inst(1, A_I, 0, 1));
      apply("lk_drain", ii(0, 0, 0, 1), o_none(1, 0));

      // Data lock reaches the starvation limit at accept; inst wins next.
      t = ii(1, 1, 1, 0);
      t.daddr = D2;
      apply("st_d1", t, o_data(1, t, 0, 0));
      t.dok = 1'b1;
      apply("st_d2", t, o_data(1, t, 0, 1));
      t.aok = 1'b0;
      apply("st_lk1", t, o_data(0, t, 0, 1));
      t.dok = 1'b0;
      apply("st_lk2", t, o_data(0, t, 0, 0));
      t.aok = 1'b1;
      apply("st_d3", t, o_data(1, t, 0, 0));
      t.dok = 1'b1;
      apply("st_i", t, o_inst(1, A_I, 0, 1));
      apply("st_drain", ii(0, 0, 0, 1), o_none(1, 0));

      // Reset with two requests in flight drops their responses.
      apply("rm_i", ii(1, 0, 1, 0), o_inst(1, A_I, 0, 0));
      t = ii(0, 1, 1, 0);
      apply("rm_d", t, o_data(1, t, 0, 0));
      t = ii(0, 0, 0, 1);
      t.rst = 1'b1;
      apply("rm_rst", t, o_none(0, 0));
      apply("rm_stale1", ii(0, 0, 0, 1), o_none(0, 0));
      apply("rm_stale2", ii(0, 0, 0, 1), o_none(0, 0));
      apply("rm_fresh", ii(1, 0, 1, 0), o_inst(1, A_I, 0, 0));
      apply("rm_rsp", ii(0, 0, 0, 1), o_none(1, 0));

      // Random traffic; requesters hold fields until accepted.
      cur     = ii(0, 0, 0, 0);
      cur.rst = 1'b1;
      model_step(cur, e);
      apply("rand_rst", cur, e);
      i_acc = 1'b0;
      d_acc = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         nxt     = cur;
         nxt.rst = ($urandom_range(0, 199) == 0);
         if (!cur.ireq || i_acc || cur.rst) begin
            nxt.ireq  = ($urandom_range(0, 2) != 0);
            nxt.iaddr = $urandom() & 32'hffff_fffc;
         end
         if (!cur.dreq || d_acc || cur.rst) begin
            nxt.dreq   = ($urandom_range(0, 2) != 0);
            nxt.dwr    = 1'($urandom_range(0, 1));
            nxt.dsize  = 2'($urandom_range(0, 2));
            nxt.dstrb  = 4'($urandom());
            nxt.daddr  = $urandom();
            nxt.dwdata = $urandom();
         end
         nxt.aok   = ($urandom_range(0, 3) != 0);
         nxt.dok   = ($urandom_range(0, 2) == 0);
         nxt.rdata = $urandom() | 32'd1;
         model_step(nxt, e);
         apply("rand", nxt, e);
         i_acc = e.iaok;
         d_acc = e.daok;
         cur   = nxt;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
